// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with 2-bit counters in static, bimodal or gshare mode.
// Lookup is combinational from registered state; one resolved update per cycle.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int MODE    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] lk_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_jump,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] mispredict_cnt,
  output logic [31:0] update_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] jumps;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [31:0]        targets [ENTRIES];
  logic [1:0]         ctr     [ENTRIES];
  logic [IDX_W-1:0]   ghr;

  logic [IDX_W-1:0] lk_idx, lk_cidx, up_idx, up_cidx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, up_alloc;
  logic [1:0]       ctr_cur, ctr_next;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx  = upd_pc[IDX_W+1:2];
  assign up_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_cidx = (MODE == 2) ? (lk_idx ^ ghr) : lk_idx;
  assign up_cidx = (MODE == 2) ? (up_idx ^ ghr) : up_idx;

  // Upper PC bits beyond the tag and the byte offset do not participate.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], lk_pc[31:IDX_W+TAG_W+2],
                            upd_pc[1:0], upd_pc[31:IDX_W+TAG_W+2]};

  always_comb begin
    pred_hit    = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    if (pred_hit) begin
      pred_target = targets[lk_idx];
      if (MODE == 0) pred_taken = jumps[lk_idx];
      else           pred_taken = jumps[lk_idx] | ctr[lk_cidx][1];
    end
  end

  assign up_hit   = valid[up_idx] && (tags[up_idx] == up_tag);
  assign up_alloc = !up_hit && upd_taken;

  always_comb begin
    ctr_cur  = ctr[up_cidx];
    ctr_next = ctr_cur;
    if (up_alloc)              ctr_next = upd_jump ? 2'b11 : 2'b10;
    else if (up_hit && upd_jump) ctr_next = 2'b11;
    else if (upd_taken)        ctr_next = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
    else                       ctr_next = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid          <= '0;
      ghr            <= '0;
      update_cnt     <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (upd_valid) begin
      if (up_alloc) valid[up_idx] <= 1'b1;
      ctr[up_cidx] <= ctr_next;
      // History is non-speculative and only tracks conditional branches.
      if (MODE == 2 && !upd_jump) ghr <= {ghr[IDX_W-2:0], upd_taken};
      if (update_cnt != 32'hFFFF_FFFF) update_cnt <= update_cnt + 32'd1;
      if (upd_mispredict && mispredict_cnt != 32'hFFFF_FFFF)
        mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  // Payload needs no reset; valid bits gate its visibility.
  always_ff @(posedge clk) begin
    if (upd_valid && (up_hit || up_alloc)) begin
      tags[up_idx]    <= up_tag;
      targets[up_idx] <= upd_target;
      jumps[up_idx]   <= upd_jump;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: three predictor instances (static, bimodal, gshare) share one stimulus stream.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] lk_pc;
  logic        upd_valid, upd_taken, upd_jump, upd_mispredict;
  logic [31:0] upd_pc, upd_target;

  logic        hit0, tk0, hit1, tk1, hit2, tk2;
  logic [31:0] tg0, tg1, tg2, mc0, uc0, mc1, uc1, mc2, uc2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .TAG_W(8), .MODE(0)) u_m0 (
    .clk(clk), .reset_n(reset_n), .lk_pc(lk_pc),
    .pred_hit(hit0), .pred_taken(tk0), .pred_target(tg0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_jump(upd_jump),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .mispredict_cnt(mc0), .update_cnt(uc0));

  branch_predictor #(.ENTRIES(64), .TAG_W(8), .MODE(1)) u_m1 (
    .clk(clk), .reset_n(reset_n), .lk_pc(lk_pc),
    .pred_hit(hit1), .pred_taken(tk1), .pred_target(tg1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_jump(upd_jump),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .mispredict_cnt(mc1), .update_cnt(uc1));

  branch_predictor #(.ENTRIES(64), .TAG_W(8), .MODE(2)) u_m2 (
    .clk(clk), .reset_n(reset_n), .lk_pc(lk_pc),
    .pred_hit(hit2), .pred_taken(tk2), .pred_target(tg2),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_jump(upd_jump),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .mispredict_cnt(mc2), .update_cnt(uc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic jump,
                     input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_jump = jump;
    upd_target = tgt; upd_mispredict = mis;
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lk_pc = pc; #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; lk_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_jump = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    #12;
    chk("rst_hit", {31'd0, hit1}, 32'd0);
    chk("rst_taken", {31'd0, tk1}, 32'd0);
    chk("rst_target", tg1, 32'h0);
    chk("rst_upd_cnt", uc1, 32'd0);
    chk("rst_mis_cnt", mc1, 32'd0);
    chk("rst_ghr", {26'd0, u_m2.ghr}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Bimodal: allocate, then walk the counter through both saturation points
    upd(32'h100, 1'b1, 1'b0, 32'h200, 1'b0);
    look(32'h100);
    chk("m1_alloc_hit", {31'd0, hit1}, 32'd1);
    chk("m1_alloc_taken", {31'd0, tk1}, 32'd1);
    chk("m1_alloc_target", tg1, 32'h200);
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b0; upd_jump = 1'b0; upd_target = 32'h200;
    #1 chk("m1_no_bypass", {31'd0, tk1}, 32'd1);
    @(posedge clk); #1; upd_valid = 1'b0;
    chk("m1_nt1_taken", {31'd0, tk1}, 32'd0);
    chk("m1_nt1_hit", {31'd0, hit1}, 32'd1);
    upd(32'h100, 1'b0, 1'b0, 32'h200, 1'b0);
    upd(32'h100, 1'b0, 1'b0, 32'h200, 1'b0);
    upd(32'h100, 1'b1, 1'b0, 32'h200, 1'b0);
    chk("m1_floor_sat", {31'd0, tk1}, 32'd0);
    upd(32'h100, 1'b1, 1'b0, 32'h200, 1'b0);
    chk("m1_weak_taken", {31'd0, tk1}, 32'd1);
    upd(32'h100, 1'b1, 1'b0, 32'h200, 1'b0);
    upd(32'h100, 1'b1, 1'b0, 32'h200, 1'b0);
    upd(32'h100, 1'b0, 1'b0, 32'h200, 1'b0);
    chk("m1_ceil_sat", {31'd0, tk1}, 32'd1);
    upd(32'h100, 1'b0, 1'b0, 32'h204, 1'b0);
    chk("m1_nt_weak", {31'd0, tk1}, 32'd0);
    chk("m1_tgt_rewrite", tg1, 32'h204);

    // Alias at pidx 0: 0x200 evicts 0x100; a not-taken miss does not allocate
    upd(32'h200, 1'b1, 1'b0, 32'h300, 1'b0);
    look(32'h100);
    chk("alias_old_hit", {31'd0, hit1}, 32'd0);
    chk("alias_old_tgt", tg1, 32'h0);
    look(32'h200);
    chk("alias_new_hit", {31'd0, hit1}, 32'd1);
    chk("alias_new_tgt", tg1, 32'h300);
    upd(32'h500, 1'b0, 1'b0, 32'h600, 1'b0);
    look(32'h500);
    chk("nt_miss_noalloc", {31'd0, hit1}, 32'd0);
    look(32'h200);
    chk("nt_miss_keep", {31'd0, hit1}, 32'd1);
    chk("nt_miss_dec", {31'd0, tk1}, 32'd0);

    // Static mode: only jumps predict taken
    do_reset();
    upd(32'h40, 1'b1, 1'b0, 32'h1000, 1'b0);
    upd(32'h80, 1'b1, 1'b1, 32'h400, 1'b0);
    look(32'h40);
    chk("m0_cond_hit", {31'd0, hit0}, 32'd1);
    chk("m0_cond_taken", {31'd0, tk0}, 32'd0);
    look(32'h80);
    chk("m0_jal_taken", {31'd0, tk0}, 32'd1);
    chk("m0_jal_tgt", tg0, 32'h400);

    // Gshare: T, J, NT, T -> history 101; counters written at pidx ^ old ghr
    do_reset();
    upd(32'h100, 1'b1, 1'b0, 32'h110, 1'b0);
    upd(32'h204, 1'b1, 1'b1, 32'h300, 1'b0);
    upd(32'h308, 1'b0, 1'b0, 32'h0,   1'b0);
    upd(32'h100, 1'b1, 1'b0, 32'h110, 1'b0);
    chk("m2_ghr", {26'd0, u_m2.ghr}, 32'h5);
    look(32'h100);
    chk("m2_xor_hit", {31'd0, hit2}, 32'd1);
    chk("m2_xor_taken", {31'd0, tk2}, 32'd0);
    chk("m1_same_taken", {31'd0, tk1}, 32'd1);
    look(32'h204);
    chk("m2_jump_taken", {31'd0, tk2}, 32'd1);
    upd(32'h204, 1'b1, 1'b1, 32'h300, 1'b0);
    chk("m2_jump_noshift", {26'd0, u_m2.ghr}, 32'h5);

    // Perf counters: 10 updates, 4 mispredicts, 2 unqualified mispredict pulses
    do_reset();
    for (int i = 0; i < 10; i++) begin
      upd(32'h1000 + 32'(i * 4), i[0], 1'b0, 32'h2000, (i % 3) == 0);
      if (i == 4 || i == 7) begin
        upd_mispredict = 1'b1; @(posedge clk); #1; upd_mispredict = 1'b0;
      end
    end
    chk("perf_upd_cnt", uc1, 32'd10);
    chk("perf_mis_cnt", mc1, 32'd4);
    look(32'h1000);
    chk("perf_pre_rst_hit", {31'd0, hit1}, 32'd0);
    look(32'h1004);
    chk("perf_alloc_hit", {31'd0, hit1}, 32'd1);
    upd_valid = 1'b1; upd_pc = 32'h1004; upd_taken = 1'b1; upd_mispredict = 1'b1;
    reset_n = 1'b0; #1;
    chk("mid_rst_upd_cnt", uc1, 32'd0);
    chk("mid_rst_mis_cnt", mc1, 32'd0);
    chk("mid_rst_hit", {31'd0, hit1}, 32'd0);
    @(negedge clk); reset_n = 1'b1; upd_mispredict = 1'b0;
    @(posedge clk); #1; upd_valid = 1'b0;
    chk("first_upd_after_rst", uc1, 32'd1);
    chk("first_upd_alloc", {31'd0, hit1}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
